// File: rtl/dm_pipeline_stage_pkg.sv
// dm_pipeline_stage_pkg: load-type codes and shared constants for the data-memory pipeline.
package dm_pipeline_stage_pkg;
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;
    localparam logic [2:0] DATA_CACHE_LOAD_NONE = 3'b000;
    localparam logic [2:0] DATA_CACHE_LOAD_LB   = 3'b001;
    localparam logic [2:0] DATA_CACHE_LOAD_LH   = 3'b010;
    localparam logic [2:0] DATA_CACHE_LOAD_LW   = 3'b011;
    localparam logic [2:0] DATA_CACHE_LOAD_LBU  = 3'b100;
    localparam logic [2:0] DATA_CACHE_LOAD_LHU  = 3'b101;
    localparam logic [4:0] BUBBLE_RD = 5'd0;
endpackage

// File: rtl/dm_pipeline_stage_load_data_extract.sv
// load_data_extract: selects and extends the byte/halfword of a cache word; flags misaligned halfword/word loads.
module load_data_extract
    import dm_pipeline_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            load,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  misaligned
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        data = (load == DATA_CACHE_LOAD_LB)  ? {{(DATA_WIDTH-8){b[7]}}, b} :
               (load == DATA_CACHE_LOAD_LBU) ? {{(DATA_WIDTH-8){LOW}}, b} :
               (load == DATA_CACHE_LOAD_LH)  ? {{(DATA_WIDTH-16){h[15]}}, h} :
               (load == DATA_CACHE_LOAD_LHU) ? {{(DATA_WIDTH-16){LOW}}, h} : word;
        // reserved codes 110/111 behave as LW
        misaligned = (load == DATA_CACHE_LOAD_LH || load == DATA_CACHE_LOAD_LHU) ? off[0] :
                     (load == DATA_CACHE_LOAD_LW || load[2:1] == 2'b11) ? (off != 2'b00) : LOW;
    end
endmodule

// File: rtl/dm_pipeline_stage.sv
// dm_pipeline_stage: DM1->DM2->DM3 data-memory pipe plus writeback register.
// Optional macro LOAD_MISALIGN_DETECT_EN adds MISALIGNED_LOAD_WB and suppresses writes of misaligned loads.
module dm_pipeline_stage
    import dm_pipeline_stage_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADD_WIDTH    = 5,
    parameter int D_CACHE_LW_WIDTH = 3
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        STALL_DATA_MEMORY_STAGE,
    input  logic                        CLEAR_EXECUTION_STAGE,
    input  logic                        DATA_CACHE_READY,
    input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_EXECUTION,
    input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_EXECUTION,
    input  logic                        WB_EN_EXECUTION,
    input  logic [DATA_WIDTH-1:0]       ALU_RESULT_EXECUTION,
    input  logic [DATA_WIDTH-1:0]       DATA_CACHE_DATA_DM3,
    output logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM1,
    output logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM2,
    output logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM3,
    output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM1,
    output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM2,
    output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM3,
    output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_WB,
    output logic                        WB_EN_WB,
`ifdef LOAD_MISALIGN_DETECT_EN
    output logic                        MISALIGNED_LOAD_WB,
`endif
    output logic [DATA_WIDTH-1:0]       WB_DATA_WB
);
`ifdef LOAD_MISALIGN_DETECT_EN
    localparam logic MIS_EN = HIGH;
`else
    localparam logic MIS_EN = LOW;
`endif
    logic                  adv, mis;
    logic                  we1, we2, we3;
    logic [DATA_WIDTH-1:0] res1, res2, res3, ext, wb_data;
    assign adv = DATA_CACHE_READY & ~STALL_DATA_MEMORY_STAGE;
    assign wb_data = (DATA_CACHE_LOAD_DM3 == DATA_CACHE_LOAD_NONE) ? res3 : ext;
    load_data_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .load       (DATA_CACHE_LOAD_DM3),
        .off        (res3[1:0]),
        .word       (DATA_CACHE_DATA_DM3),
        .data       (ext),
        .misaligned (mis)
    );
    always_ff @(posedge CLK) begin
        if (RST_N == LOW) begin
            {RD_ADDRESS_DM1, RD_ADDRESS_DM2, RD_ADDRESS_DM3, RD_ADDRESS_WB} <= '0;
            {DATA_CACHE_LOAD_DM1, DATA_CACHE_LOAD_DM2, DATA_CACHE_LOAD_DM3} <= '0;
            {we1, we2, we3, WB_EN_WB} <= '0;
            {res1, res2, res3, WB_DATA_WB} <= '0;
`ifdef LOAD_MISALIGN_DETECT_EN
            MISALIGNED_LOAD_WB <= LOW;
`endif
        end else begin
            // strobe only on the advancing cycle so each instruction writes once
            WB_EN_WB <= adv & we3 & (RD_ADDRESS_DM3 != '0) & ~(MIS_EN & mis);
`ifdef LOAD_MISALIGN_DETECT_EN
            MISALIGNED_LOAD_WB <= adv & mis;
`endif
            if (adv) begin
                RD_ADDRESS_DM1      <= CLEAR_EXECUTION_STAGE ? REG_ADD_WIDTH'(BUBBLE_RD) : RD_ADDRESS_EXECUTION;
                DATA_CACHE_LOAD_DM1 <= CLEAR_EXECUTION_STAGE ? DATA_CACHE_LOAD_NONE : DATA_CACHE_LOAD_EXECUTION;
                we1                 <= CLEAR_EXECUTION_STAGE ? LOW : WB_EN_EXECUTION;
                res1                <= CLEAR_EXECUTION_STAGE ? '0 : ALU_RESULT_EXECUTION;
                RD_ADDRESS_DM2      <= RD_ADDRESS_DM1;
                DATA_CACHE_LOAD_DM2 <= DATA_CACHE_LOAD_DM1;
                we2                 <= we1;
                res2                <= res1;
                RD_ADDRESS_DM3      <= RD_ADDRESS_DM2;
                DATA_CACHE_LOAD_DM3 <= DATA_CACHE_LOAD_DM2;
                we3                 <= we2;
                res3                <= res2;
                RD_ADDRESS_WB       <= RD_ADDRESS_DM3;
                WB_DATA_WB          <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_dm_pipeline_stage.sv
// tb_dm_pipeline_stage: scoreboard bench for dm_pipeline_stage with a queue-based reference model.
module tb_dm_pipeline_stage;
`ifdef LOAD_MISALIGN_DETECT_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    typedef struct packed {
        logic [4:0]  rd;
        logic [2:0]  ld;
        logic        we;
        logic [31:0] res;
    } ent_t;
    localparam ent_t BUB = '0;

    logic        clk = 1'b0;
    logic        RST_N, STALL, CLEAR, READY, WB_EN_EXECUTION, WB_EN_WB;
    logic [4:0]  RD_EX, RD1, RD2, RD3, RD_WB;
    logic [2:0]  LD_EX, LD1, LD2, LD3;
    logic [31:0] ALU, CACHE, WB_DATA;
    logic        mis_out;

    ent_t        pipe[$];
    logic [36:0] sb[$];
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fix_cache = 1'b0;
    logic [31:0] cword = '0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    dm_pipeline_stage dut (
        .CLK                       (clk),
        .RST_N                     (RST_N),
        .STALL_DATA_MEMORY_STAGE   (STALL),
        .CLEAR_EXECUTION_STAGE     (CLEAR),
        .DATA_CACHE_READY          (READY),
        .RD_ADDRESS_EXECUTION      (RD_EX),
        .DATA_CACHE_LOAD_EXECUTION (LD_EX),
        .WB_EN_EXECUTION           (WB_EN_EXECUTION),
        .ALU_RESULT_EXECUTION      (ALU),
        .DATA_CACHE_DATA_DM3       (CACHE),
        .DATA_CACHE_LOAD_DM1       (LD1),
        .DATA_CACHE_LOAD_DM2       (LD2),
        .DATA_CACHE_LOAD_DM3       (LD3),
        .RD_ADDRESS_DM1            (RD1),
        .RD_ADDRESS_DM2            (RD2),
        .RD_ADDRESS_DM3            (RD3),
        .RD_ADDRESS_WB             (RD_WB),
        .WB_EN_WB                  (WB_EN_WB),
`ifdef LOAD_MISALIGN_DETECT_EN
        .MISALIGNED_LOAD_WB        (mis_out),
`endif
        .WB_DATA_WB                (WB_DATA)
    );
`ifndef LOAD_MISALIGN_DETECT_EN
    assign mis_out = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (int'(a[1:0]) * 8));
        h = 16'(w >> (a[1] ? 16 : 0));
        case (ld)
            3'd0:    return a;
            3'd1:    return 32'($signed(b));
            3'd4:    return {24'd0, b};
            3'd2:    return 32'($signed(h));
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [2:0] ld, input logic [1:0] off);
        if (ld == 3'd2 || ld == 3'd5) return off[0];
        if (ld == 3'd3 || ld >= 3'd6) return off != 2'd0;
        return 1'b0;
    endfunction

    task automatic step(input logic rn, input logic clr, input logic stall, input logic rdy,
                        input logic [4:0] rd, input logic [2:0] ld, input logic we, input logic [31:0] res);
        ent_t        e, o;
        logic [31:0] d;
        bit          m, exp_mis;
        @(negedge clk);
        RST_N = rn; CLEAR = clr; STALL = stall; READY = rdy;
        RD_EX = rd; LD_EX = ld; WB_EN_EXECUTION = we; ALU = res;
        CACHE = fix_cache ? cword : $urandom;
        @(posedge clk);
        exp_mis = 1'b0;
        if (!rn) begin
            pipe = '{BUB, BUB, BUB};
            wb_rd = '0;
            wb_data = '0;
        end else if (rdy && !stall) begin
            e = clr ? BUB : '{rd: rd, ld: ld, we: we, res: res};
            pipe.push_front(e);
            o = pipe.pop_back();
            d = ref_load(o.ld, o.res, CACHE);
            m = ref_mis(o.ld, o.res[1:0]);
            wb_rd = o.rd;
            wb_data = d;
            if (o.we && o.rd != 0 && !(MIS_EN && m)) sb.push_back({o.rd, d});
            exp_mis = MIS_EN && m;
        end
        #1;
        chk("dm_rd", 64'({RD1, RD2, RD3}), 64'({pipe[0].rd, pipe[1].rd, pipe[2].rd}));
        chk("dm_load", 64'({LD1, LD2, LD3}), 64'({pipe[0].ld, pipe[1].ld, pipe[2].ld}));
        chk("wb_regs", 64'({RD_WB, WB_DATA}), 64'({wb_rd, wb_data}));
        if (MIS_EN) chk("misaligned", 64'(mis_out), 64'(exp_mis));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 1'b0, 32'd0);
    endtask

    task automatic run_load(input string name, input logic [2:0] ld, input logic [31:0] a,
                            input logic [31:0] w, input logic [31:0] exp);
        fix_cache = 1'b1;
        cword = w;
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, ld, 1'b1, a);
        repeat (3) idle();
        chk(name, 64'(WB_DATA), 64'(exp));
        chk({name, "_strobe"}, 64'(WB_EN_WB), 64'(1));
        fix_cache = 1'b0;
    endtask

    // monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (WB_EN_WB === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wb_write: got unexpected write rd=%0d data=%h, required none", RD_WB, WB_DATA);
            end else begin
                chk("wb_write", 64'({RD_WB, WB_DATA}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        pipe = '{BUB, BUB, BUB};
        wb_rd = '0;
        wb_data = '0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("idle_wb_en", 64'(WB_EN_WB), 64'(0));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 3'd0, 1'b1, 32'h1234_5678);
        chk("add_dm1", 64'(RD1), 64'(7));
        idle();
        chk("add_dm2", 64'(RD2), 64'(7));
        idle();
        chk("add_dm3", 64'(RD3), 64'(7));
        idle();
        chk("add_wb", 64'({WB_EN_WB, RD_WB, WB_DATA}), 64'({1'b1, 5'd7, 32'h1234_5678}));
        run_load("lb", 3'd1, 32'h0000_1003, 32'h80AA_BBCC, 32'hFFFF_FF80);
        run_load("lbu", 3'd4, 32'h0000_1003, 32'h80AA_BBCC, 32'h0000_0080);
        run_load("lhu", 3'd5, 32'h0000_1002, 32'h80AA_BBCC, 32'h0000_80AA);
        run_load("lh", 3'd2, 32'h0000_1000, 32'h1234_F00D, 32'hFFFF_F00D);
        run_load("lw", 3'd3, 32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 3'd3, 1'b1, 32'h0000_0040);
        idle();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 3'd1, 1'b1, 32'h55);
            chk("stall_wb_en", 64'(WB_EN_WB), 64'(0));
            chk("stall_dm2", 64'(RD2), 64'(5));
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 3'd1, 1'b1, 32'h55);
        chk("clr_stall_dm2", 64'(RD2), 64'(5));
        idle();
        idle();
        chk("stall_release", 64'({WB_EN_WB, RD_WB}), 64'({1'b1, 5'd5}));
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 3'd3, 1'b1, 32'h77);
        chk("clr_dm1", 64'({RD1, LD1}), 64'(0));
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 3'd0, 1'b1, 32'h99);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 1'b1, 32'hABC);
        repeat (2) idle();
        chk("after_clr", 64'({WB_EN_WB, RD_WB}), 64'({1'b1, 5'd10}));
        idle();
        chk("rd0_no_write", 64'(WB_EN_WB), 64'(0));
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 3'd3, 1'b1, 32'h10);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 3'd1, 1'b1, 32'h11);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 3'd5, 1'b1, 32'h12);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 3'd3, 1'b1, 32'h13);
        chk("reset_flush", 64'({RD1, RD2, RD3, LD1, LD2, LD3, WB_EN_WB}), 64'(0));
`ifdef LOAD_MISALIGN_DETECT_EN
        fix_cache = 1'b1;
        cword = 32'hCAFE_F00D;
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 3'd3, 1'b1, 32'h0000_0101);
        repeat (3) idle();
        chk("mis_lw", 64'({mis_out, WB_EN_WB}), 64'({1'b1, 1'b0}));
        idle();
        chk("mis_clear", 64'(mis_out), 64'(0));
        fix_cache = 1'b0;
`endif
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) != 0, $urandom_range(9) == 0, $urandom_range(6) == 0,
                 $urandom_range(7) != 0, ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
                 3'($urandom), 1'($urandom), $urandom);
        end
        repeat (5) idle();
        @(negedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dm_pipeline_stage.md
Name: dm_pipeline_stage

Overview:
- Three-deep data-memory pipeline (DM1→DM2→DM3) plus writeback register, directly downstream of the execution stage.
- Carries rd address, load type, writeback enable and ALU result/address through the data-cache latency.
- Extracts and extends load data at DM3 and presents the writeback triple.
- Feeds the hazard control unit its DATA_CACHE_LOAD_DMx / RD_ADDRESS_DMx inputs and consumes its STALL_DATA_MEMORY_STAGE and CLEAR_EXECUTION_STAGE outputs.

Parameters:
- DATA_WIDTH, 32, ALU result / cache data width
- REG_ADD_WIDTH, 5, register address width
- D_CACHE_LW_WIDTH, 3, load-type code width

Ports:
- CLK  in  1  clock; single clock domain
- RST_N  in  1  synchronous, active-low reset
- STALL_DATA_MEMORY_STAGE  in  1  hold entire DM pipe
- CLEAR_EXECUTION_STAGE  in  1  execution output invalid; inject bubble into DM1
- DATA_CACHE_READY  in  1  cache can accept/return this cycle
- RD_ADDRESS_EXECUTION  in  REG_ADD_WIDTH  destination register
- DATA_CACHE_LOAD_EXECUTION  in  D_CACHE_LW_WIDTH  load type code
- WB_EN_EXECUTION  in  1  instruction writes rd
- ALU_RESULT_EXECUTION  in  DATA_WIDTH  result or load address
- DATA_CACHE_DATA_DM3  in  DATA_WIDTH  cache read word aligned with the DM3 entry
- DATA_CACHE_LOAD_DM1/DM2/DM3  out  D_CACHE_LW_WIDTH each  per-stage load type
- RD_ADDRESS_DM1/DM2/DM3  out  REG_ADD_WIDTH each  per-stage rd
- RD_ADDRESS_WB  out  REG_ADD_WIDTH  writeback rd
- WB_EN_WB  out  1  register-file write strobe
- WB_DATA_WB  out  DATA_WIDTH  writeback data

Behaviour:
- Load codes: 000 NONE, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 reserved, treated as LW.
- adv = DATA_CACHE_READY & ~STALL_DATA_MEMORY_STAGE.
- On adv:
  - DM1 ← execution inputs, or a bubble if CLEAR_EXECUTION_STAGE.
  - DM2 ← DM1; DM3 ← DM2; WB ← processed DM3.
- Bubble: rd=0, load=NONE, wb_en=0, result=0.
- Not adv: DM1..DM3 and RD_ADDRESS_WB/WB_DATA_WB hold; WB_EN_WB forced 0 (one write per instruction).
- CLEAR while not adv: ignored; the hazard unit re-asserts it while the hazard persists.
- Latency: execution input → WB outputs in 4 adv cycles.
- DM outputs are direct register outputs, visible the cycle after capture.
- DM3 processing, off = ALU result[1:0]:
  - NONE: data = ALU result.
  - LB/LBU: byte at off, sign/zero-extended.
  - LH/LHU: halfword at off[1], sign/zero-extended; off[0] ignored.
  - LW: full word; off ignored.
- WB_EN_WB = DM3 wb_en & (rd != 0) on adv.
- Reset (RST_N=0 at a CLK edge): all DM stages become bubbles; RD_ADDRESS_WB=0, WB_EN_WB=0, WB_DATA_WB=0. Reset overrides adv and CLEAR.
- Reset mid-operation discards in-flight entries with no write strobe.
- Simultaneous CLEAR and STALL: stall wins, nothing moves.

Optional Feature:
- Macro LOAD_MISALIGN_DETECT_EN.
- Defined:
  - Adds output MISALIGNED_LOAD_WB (1 bit).
  - Set on adv when DM3 is LH/LHU with off[0]=1, or LW/reserved with off≠0.
  - When set, WB_EN_WB is forced 0 for that instruction.
  - Reset value 0; cleared on the next adv or any non-adv cycle.
- Undefined: port absent; misaligned loads handled per the extraction rules above.

Decomposition:
- Shared package (include file): load code constants (DATA_CACHE_LOAD_NONE/LB/LH/LW/LBU/LHU), bubble rd constant, HIGH/LOW.
- One sub-module, load_data_extract: combinational byte/half select plus extension; inputs load code, offset, data word; outputs extended data and misaligned flag.
- The pipeline registers stay in the parent.

Test Plan:
- Reset then idle: all DM outputs 0 / NONE, WB_EN_WB=0 for 10 cycles.
- ADD-type (load NONE, rd=7, result 0x1234_5678, wb_en=1), adv every cycle: RD_ADDRESS_DM1/2/3 = 7 on cycles 1/2/3; cycle 4 WB_EN_WB=1, RD_ADDRESS_WB=7, WB_DATA_WB=0x1234_5678.
- LB at addr 0x...03, cache word 0x80AA_BBCC: WB_DATA_WB = 0xFFFF_FF80. LBU gives 0x0000_0080. LHU at 0x...02 gives 0x0000_80AA.
- STALL held 3 cycles with a load in DM2: all DM outputs frozen, WB_EN_WB=0 throughout; after release, WB written exactly once.
- CLEAR_EXECUTION_STAGE pulse with adv: DM1 = rd 0 / NONE; the following entry flows normally. Write to rd=0 with wb_en=1: WB_EN_WB stays 0.
- Reset asserted with loads in DM1..DM3: next cycle all stages NONE, no write strobe. With LOAD_MISALIGN_DETECT_EN, LW at 0x...01: MISALIGNED_LOAD_WB=1, WB_EN_WB=0.
